// File: rtl/sfp_event_timestamp.sv
// ---------------------------------------------------------------------------
// sfp_event_timestamp
//
// Timestamp stage that sits right after the SFP event-receiver decode. It runs
// entirely in the recovered event clock domain.
//   - 0x70 / 0x71 events shift a 0 / 1 into a 32-bit seconds word, MSB first.
//   - A 0x7D event commits that word as the new seconds value and restarts the
//     sub-second tick counter.
//   - A watchdog supervises the 0x7A heartbeat event.
//   - If the link drops, synchronisation is lost, but the last seconds value
//     is kept.
//
// Ports
//   event_clk_i     in   1   recovered event clock (sole clock)
//   reset_i         in   1   synchronous, active-high reset
//   link_ok_i       in   1   receiver link up
//   event_code_i    in   8   event code
//   event_valid_i   in   1   event code is qualified (data char, no errors)
//   seconds_o       out  32  committed seconds value
//   ticks_o         out  32  clock cycles since last committed 0x7D (saturating)
//   synced_o        out  1   seconds_o is valid
//   ts_strobe_o     out  1   pulse: seconds_o was (re)loaded
//   sec_mismatch_o  out  1   pulse: received seconds != previous seconds + 1
//   sec_short_o     out  1   pulse: 0x7D arrived before 32 bits were shifted
//   hb_lost_o       out  1   heartbeat watchdog expired
//
// Every output is a register and responds one cycle after the input cycle
// that caused the change.
// ---------------------------------------------------------------------------
module sfp_event_timestamp #(
  parameter logic [31:0] HB_TIMEOUT = 32'd125000000
) (
  input  logic        event_clk_i,
  input  logic        reset_i,
  input  logic        link_ok_i,
  input  logic [7:0]  event_code_i,
  input  logic        event_valid_i,
  output logic [31:0] seconds_o,
  output logic [31:0] ticks_o,
  output logic        synced_o,
  output logic        ts_strobe_o,
  output logic        sec_mismatch_o,
  output logic        sec_short_o,
  output logic        hb_lost_o
);

  localparam logic [7:0] EV_BIT0  = 8'h70;
  localparam logic [7:0] EV_BIT1  = 8'h71;
  localparam logic [7:0] EV_HBEAT = 8'h7A;
  localparam logic [7:0] EV_SECS  = 8'h7D;

  typedef enum logic {ST_UNSYNC, ST_SYNCED} state_t;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t      r_state;
  logic [31:0] r_shift;
  logic [5:0]  r_bit_cnt;
  logic [31:0] r_seconds;
  logic [31:0] r_ticks;
  logic        r_synced;
  logic        r_strobe;
  logic        r_mismatch;
  logic        r_short;
  logic [31:0] r_wdog;
  logic        r_hb_lost;

  // ---------------------------------------------------------------------
  // Event decode. Only qualified cycles are decoded.
  // ---------------------------------------------------------------------
  logic w_ev_bit0;
  logic w_ev_bit1;
  logic w_ev_hbeat;
  logic w_ev_secs;
  logic w_full;

  assign w_ev_bit0  = event_valid_i && (event_code_i == EV_BIT0);
  assign w_ev_bit1  = event_valid_i && (event_code_i == EV_BIT1);
  assign w_ev_hbeat = event_valid_i && (event_code_i == EV_HBEAT);
  assign w_ev_secs  = event_valid_i && (event_code_i == EV_SECS);
  assign w_full     = (r_bit_cnt == 6'd32);

  // ---------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------
  state_t      w_state_nxt;
  logic [31:0] w_shift_nxt;
  logic [5:0]  w_bit_cnt_nxt;
  logic [31:0] w_seconds_nxt;
  logic [31:0] w_ticks_nxt;
  logic        w_synced_nxt;
  logic        w_strobe_nxt;
  logic        w_mismatch_nxt;
  logic        w_short_nxt;
  logic [31:0] w_sec_pred;

  // The predicted next second. It serves both as the mismatch reference and
  // as the free-run value when a short word arrives.
  assign w_sec_pred = r_seconds + 32'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_seconds_nxt  = r_seconds;
    w_synced_nxt   = r_synced;
    w_strobe_nxt   = 1'b0;
    w_mismatch_nxt = 1'b0;
    w_short_nxt    = 1'b0;
    // The tick counter saturates so that a long-lost 0x7D is never mistaken
    // for a fresh second.
    w_ticks_nxt    = (r_ticks == 32'hFFFF_FFFF) ? r_ticks : r_ticks + 32'd1;

    if (!link_ok_i) begin
      // Link loss outranks every event on the same cycle, including 0x7D.
      // The seconds value is kept for observation, but it is no longer
      // trusted.
      w_state_nxt   = ST_UNSYNC;
      w_synced_nxt  = 1'b0;
      w_shift_nxt   = '0;
      w_bit_cnt_nxt = '0;
      w_ticks_nxt   = '0;
    end else if (w_ev_secs) begin
      w_shift_nxt   = '0;
      w_bit_cnt_nxt = '0;
      w_ticks_nxt   = '0;
      unique case (r_state)
        ST_UNSYNC: begin
          if (w_full) begin
            w_state_nxt   = ST_SYNCED;
            w_seconds_nxt = r_shift;
            w_synced_nxt  = 1'b1;
            w_strobe_nxt  = 1'b1;
          end else begin
            w_short_nxt   = 1'b1;
          end
        end
        ST_SYNCED: begin
          w_strobe_nxt = 1'b1;
          if (w_full) begin
            w_seconds_nxt  = r_shift;
            w_mismatch_nxt = (r_shift != w_sec_pred);
          end else begin
            // No complete word arrived, so keep counting seconds locally.
            w_seconds_nxt = w_sec_pred;
            w_short_nxt   = 1'b1;
          end
        end
        default: w_state_nxt = ST_UNSYNC;
      endcase
    end else if (w_ev_bit0 || w_ev_bit1) begin
      // After 32 bits the oldest bit falls off the top, so the register
      // always holds the newest 32 bits.
      w_shift_nxt   = {r_shift[30:0], w_ev_bit1};
      w_bit_cnt_nxt = w_full ? 6'd32 : r_bit_cnt + 6'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Timestamp state registers
  // ---------------------------------------------------------------------
  always_ff @(posedge event_clk_i) begin
    if (reset_i) begin
      r_state    <= ST_UNSYNC;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_seconds  <= '0;
      r_ticks    <= '0;
      r_synced   <= 1'b0;
      r_strobe   <= 1'b0;
      r_mismatch <= 1'b0;
      r_short    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_seconds  <= w_seconds_nxt;
      r_ticks    <= w_ticks_nxt;
      r_synced   <= w_synced_nxt;
      r_strobe   <= w_strobe_nxt;
      r_mismatch <= w_mismatch_nxt;
      r_short    <= w_short_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Heartbeat watchdog. It is independent of link state. The counter parks
  // at HB_TIMEOUT-1 once expired, so the flag cannot clear until a new
  // heartbeat arrives.
  // ---------------------------------------------------------------------
  always_ff @(posedge event_clk_i) begin
    if (reset_i) begin
      r_wdog    <= '0;
      r_hb_lost <= 1'b0;
    end else if (w_ev_hbeat) begin
      r_wdog    <= '0;
      r_hb_lost <= 1'b0;
    end else if (!r_hb_lost) begin
      if (r_wdog == HB_TIMEOUT - 32'd1) begin
        r_hb_lost <= 1'b1;
      end else begin
        r_wdog <= r_wdog + 32'd1;
      end
    end
  end

  assign seconds_o      = r_seconds;
  assign ticks_o        = r_ticks;
  assign synced_o       = r_synced;
  assign ts_strobe_o    = r_strobe;
  assign sec_mismatch_o = r_mismatch;
  assign sec_short_o    = r_short;
  assign hb_lost_o      = r_hb_lost;

endmodule

// File: tb/tb_sfp_event_timestamp.sv
// Bench for sfp_event_timestamp. A cycle-level reference model keeps the
// received bits in a queue, counts cycles since the last heartbeat, and
// derives every expected output from those values. Directed scenarios run
// first, followed by randomised event traffic.
module tb_sfp_event_timestamp;

  localparam logic [31:0] HB = 32'd16;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        link_ok_i = 1'b0;
  logic [7:0]  event_code_i = 8'h00;
  logic        event_valid_i = 1'b0;
  logic [31:0] seconds_o;
  logic [31:0] ticks_o;
  logic        synced_o, ts_strobe_o, sec_mismatch_o, sec_short_o, hb_lost_o;

  sfp_event_timestamp #(.HB_TIMEOUT(HB)) dut (
    .event_clk_i    (clk),
    .reset_i        (reset_i),
    .link_ok_i      (link_ok_i),
    .event_code_i   (event_code_i),
    .event_valid_i  (event_valid_i),
    .seconds_o      (seconds_o),
    .ticks_o        (ticks_o),
    .synced_o       (synced_o),
    .ts_strobe_o    (ts_strobe_o),
    .sec_mismatch_o (sec_mismatch_o),
    .sec_short_o    (sec_short_o),
    .hb_lost_o      (hb_lost_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_sec;
  logic [31:0] m_ticks;
  bit          m_sync;
  bit          m_strobe, m_mism, m_short;
  bit          m_bits[$];
  int          m_since_hb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_word();
    logic [31:0] w = '0;
    int n = m_bits.size();
    for (int i = 0; i < 32; i++) w = {w[30:0], m_bits[n-32+i]};
    return w;
  endfunction

  task automatic model_step(input bit rst, input bit lnk, input logic [7:0] code, input bit vld);
    m_strobe = 0; m_mism = 0; m_short = 0;
    if (rst) begin
      m_sec = '0; m_ticks = '0; m_sync = 0; m_bits.delete(); m_since_hb = 0;
      return;
    end
    if (vld && code == 8'h7A) m_since_hb = 0;
    else if (m_since_hb < 1000000) m_since_hb++;
    if (!lnk) begin
      m_sync = 0; m_bits.delete(); m_ticks = '0;
    end else if (vld && code == 8'h7D) begin
      if (m_bits.size() >= 32) begin
        logic [31:0] w = m_word();
        if (m_sync) m_mism = (w != m_sec + 32'd1);
        m_sec = w; m_sync = 1; m_strobe = 1;
      end else begin
        m_short = 1;
        if (m_sync) begin m_sec = m_sec + 32'd1; m_strobe = 1; end
      end
      m_bits.delete();
      m_ticks = '0;
    end else begin
      if (m_ticks != 32'hFFFF_FFFF) m_ticks++;
      if (vld && (code == 8'h70 || code == 8'h71)) begin
        m_bits.push_back(code[0]);
        if (m_bits.size() > 32) void'(m_bits.pop_front());
      end
    end
  endtask

  // Drive one cycle, advance the model, then compare every output one time
  // unit after the edge.
  task automatic cyc(input bit rst, input bit lnk, input logic [7:0] code, input bit vld);
    reset_i = rst; link_ok_i = lnk; event_code_i = code; event_valid_i = vld;
    @(posedge clk);
    model_step(rst, lnk, code, vld);
    #1;
    chk("seconds",  seconds_o,      m_sec);
    chk("ticks",    ticks_o,        m_ticks);
    chk("synced",   {31'd0, synced_o},       {31'd0, m_sync});
    chk("strobe",   {31'd0, ts_strobe_o},    {31'd0, m_strobe});
    chk("mismatch", {31'd0, sec_mismatch_o}, {31'd0, m_mism});
    chk("short",    {31'd0, sec_short_o},    {31'd0, m_short});
    chk("hb_lost",  {31'd0, hb_lost_o},      {31'd0, (m_since_hb >= int'(HB))});
  endtask

  task automatic idle();        cyc(0, 1, 8'h00, 0); endtask
  task automatic ev(input logic [7:0] c); cyc(0, 1, c, 1); endtask
  task automatic send_word(input logic [31:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) ev(w[i] ? 8'h71 : 8'h70);
  endtask
  task automatic do_reset();
    cyc(1, 1, 8'h00, 0);
    cyc(1, 1, 8'h00, 0);
  endtask

  initial begin
    // The heartbeat expires 16 cycles after reset release.
    do_reset();
    chk("rst_seconds", seconds_o, 32'h0);
    chk("rst_synced",  {31'd0, synced_o},  32'h0);
    chk("rst_hb_lost", {31'd0, hb_lost_o}, 32'h0);
    for (int i = 0; i < 15; i++) idle();
    chk("hb_not_yet", {31'd0, hb_lost_o}, 32'h0);
    idle();
    chk("hb_rise16", {31'd0, hb_lost_o}, 32'h1);
    idle();
    ev(8'h7A);
    chk("hb_clear", {31'd0, hb_lost_o}, 32'h0);

    // Sync from the 1,0,1,0,0,1,0,1 pattern repeated four times.
    do_reset();
    send_word(32'hA5A5_A5A5, 32);
    ev(8'h7D);
    chk("t1_seconds", seconds_o, 32'hA5A5_A5A5);
    chk("t1_synced",  {31'd0, synced_o},    32'h1);
    chk("t1_strobe",  {31'd0, ts_strobe_o}, 32'h1);
    chk("t1_ticks0",  ticks_o, 32'h0);
    idle();
    chk("t1_strobe_once", {31'd0, ts_strobe_o}, 32'h0);
    chk("t1_ticks1", ticks_o, 32'h1);

    // A predicted second, then an out-of-sequence second.
    send_word(32'hA5A5_A5A6, 32); ev(8'h7D);
    chk("t2_nomism", {31'd0, sec_mismatch_o}, 32'h0);
    send_word(32'h0, 32); ev(8'h7D);
    chk("t2_sec0", seconds_o, 32'h0);
    chk("t2_mism", {31'd0, sec_mismatch_o}, 32'h1);

    // A short word makes the local count free-run, including the wrap.
    send_word(32'h1234, 16); ev(8'h7D);
    chk("t3_sec1",   seconds_o, 32'h1);
    chk("t3_short",  {31'd0, sec_short_o}, 32'h1);
    chk("t3_strobe", {31'd0, ts_strobe_o}, 32'h1);
    send_word(32'hFFFF_FFFF, 32); ev(8'h7D);
    send_word(32'h5555, 16); ev(8'h7D);
    chk("t3_wrap", seconds_o, 32'h0);
    ev(8'h7A);

    // Drop the link for one cycle in the middle of a shift.
    send_word(32'h3FF, 10);
    cyc(0, 0, 8'h71, 1);
    chk("t5_unsync", {31'd0, synced_o}, 32'h0);
    send_word(32'h1234_5678, 32);
    chk("t5_still_unsync", {31'd0, synced_o}, 32'h0);
    ev(8'h7D);
    chk("t5_sec", seconds_o, 32'h1234_5678);
    chk("t5_synced", {31'd0, synced_o}, 32'h1);

    // Unqualified events are ignored, and link loss beats a 0x7D.
    send_word(32'hCAFE_F00D, 32);
    cyc(0, 1, 8'h71, 0);
    cyc(0, 1, 8'h7D, 0);
    chk("t6_nostrobe", {31'd0, ts_strobe_o}, 32'h0);
    ev(8'h7D);
    chk("t6_sec", seconds_o, 32'hCAFE_F00D);
    send_word(32'h1111_1111, 32);
    cyc(0, 0, 8'h7D, 1);
    chk("t6_linkloss_nostrobe", {31'd0, ts_strobe_o}, 32'h0);
    chk("t6_linkloss_ticks", ticks_o, 32'h0);
    chk("t6_sec_hold", seconds_o, 32'hCAFE_F00D);

    // A reset in the middle of a shift discards the partial bits.
    send_word(32'hF, 20);
    do_reset();
    send_word(32'hF, 12);
    ev(8'h7D);
    chk("rst_mid_short", {31'd0, sec_short_o}, 32'h1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      logic [7:0] c;
      bit v = ($urandom_range(0, 9) != 0);
      bit l = ($urandom_range(0, 59) != 0);
      if (r < 80)      c = (r & 1) ? 8'h71 : 8'h70;
      else if (r < 82) c = 8'h7D;
      else if (r < 86) c = 8'h7A;
      else             c = 8'($urandom);
      if (!l && c == 8'h7A) c = 8'h00;
      cyc(0, l, c, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
